// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared CPU pipeline-control constants and FSM encoding
package pipeline_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   localparam int DIV_TIMEOUT_DEFAULT = 64;
   localparam int FLUSH_CNT_W         = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard/branch/divider inputs and pipeline enable/flush outputs
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);

   logic             stall_req;
   logic             ex_branch_taken;
   logic             ex_is_div;
   logic             div_done;
   logic             pc_en;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_bubble;
   logic             exmem_bubble;
   logic             div_start;
   logic             div_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [15:0]      flush_count;

   modport master (
      output stall_req, ex_branch_taken, ex_is_div, div_done,
      input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
      input  div_start, div_timeout, stall_cycles, flush_count
   );

   modport slave (
      input  stall_req, ex_branch_taken, ex_is_div, div_done,
      output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
      output div_start, div_timeout, stall_cycles, flush_count
   );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - enabled up-counter that sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with multi-cycle divider wait
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT,
   parameter int CNT_W       = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   pipeline_ctrl_if.slave  bus
);

   localparam int TO_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TO_W-1:0]   r_div_cnt;
   logic              r_div_timeout;
   logic              w_timeout_hit;
   logic              w_pc_en;
   logic              w_ifid_en;
   logic              w_ifid_flush;
   logic              w_idex_en;
   logic              w_idex_bubble;
   logic              w_exmem_bubble;
   logic              w_div_start;
   logic [CNT_W-1:0]  w_stall_cycles;
   logic [15:0]       w_flush_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= RUN;
         r_div_cnt     <= '0;
         r_div_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Held at zero in RUN so every DIV_WAIT entry starts counting from 0.
         if (r_state == RUN) begin
            r_div_cnt <= '0;
         end else begin
            r_div_cnt <= r_div_cnt + TO_W'(1);
         end
         if (w_timeout_hit) begin
            r_div_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_timeout_hit  = 1'b0;
      w_pc_en        = 1'b1;
      w_ifid_en      = 1'b1;
      w_ifid_flush   = 1'b0;
      w_idex_en      = 1'b1;
      w_idex_bubble  = 1'b0;
      w_exmem_bubble = 1'b0;
      w_div_start    = 1'b0;
      // Reset cycles present plain RUN outputs regardless of the held state.
      if (rst_n) begin
         case (r_state)
            RUN: begin
               if (bus.ex_is_div) begin
                  w_div_start    = 1'b1;
                  w_pc_en        = 1'b0;
                  w_ifid_en      = 1'b0;
                  w_idex_en      = 1'b0;
                  w_exmem_bubble = 1'b1;
                  w_state_nxt    = DIV_WAIT;
               end else if (bus.ex_branch_taken) begin
                  w_ifid_flush  = 1'b1;
                  w_idex_bubble = 1'b1;
               end else if (bus.stall_req) begin
                  w_pc_en       = 1'b0;
                  w_ifid_en     = 1'b0;
                  w_idex_bubble = 1'b1;
               end
            end
            DIV_WAIT: begin
               if (bus.div_done) begin
                  w_state_nxt = RUN;
               end else if (r_div_cnt == TO_LAST) begin
                  w_timeout_hit = 1'b1;
                  w_state_nxt   = RUN;
               end else begin
                  w_pc_en        = 1'b0;
                  w_ifid_en      = 1'b0;
                  w_idex_en      = 1'b0;
                  w_exmem_bubble = 1'b1;
               end
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (!w_pc_en),
      .o_count (w_stall_cycles)
   );

   sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_ifid_flush),
      .o_count (w_flush_count)
   );

   assign bus.pc_en        = w_pc_en;
   assign bus.ifid_en      = w_ifid_en;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_en      = w_idex_en;
   assign bus.idex_bubble  = w_idex_bubble;
   assign bus.exmem_bubble = w_exmem_bubble;
   assign bus.div_start    = w_div_start;
   assign bus.div_timeout  = r_div_timeout;
   assign bus.stall_cycles = w_stall_cycles;
   assign bus.flush_count  = w_flush_count;

endmodule
